instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0028, sets the first fetch address after reset (word 10).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 redirect  input  1  taken branch/jump; when high, fetching restarts at redirect_addr.
REQ-005 redirect_addr  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-006 imem_req  output  1  instruction memory request valid.
REQ-007 imem_addr  output  32  byte address of the request; always word-aligned.
REQ-008 imem_ack  input  1  memory returns imem_data for the current request this cycle.
REQ-009 imem_data  input  32  instruction word; sampled only when imem_req && imem_ack.
REQ-010 if_valid  output  1  buffer head holds a valid instruction.
REQ-011 if_instr  output  32  instruction at the buffer head.
REQ-012 if_pc  output  32  byte address of if_instr.
REQ-013 if_ready  input  1  downstream consumes the head when if_valid && if_ready.

Function
REQ-014 The block SHALL hold a fetch PC plus a 2-entry FIFO of {pc, instr} pairs; if_valid, if_instr and if_pc come from the FIFO head (registered, no combinational path from imem_* to if_*).
REQ-015 The FSM SHALL have three states: IDLE (no request), FETCH (imem_req=1), DRAIN (imem_req=1, returned data is discarded).
REQ-016 IDLE->FETCH SHALL occur when FIFO occupancy after this cycle's pop is < 2 and redirect=0; imem_addr=PC.
REQ-017 In FETCH and DRAIN, imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-018 On FETCH with ack: push {PC, imem_data}; PC<=PC+4; stay in FETCH (back-to-back) if occupancy after push and pop is < 2, else go to IDLE.
REQ-019 Pop SHALL occur on if_valid && if_ready; a push and a pop in the same cycle SHALL leave the occupancy unchanged and keep order.
REQ-020 Redirect SHALL take priority over push, pop and PC increment: FIFO flushed (if_valid=0 next cycle), PC<={redirect_addr[31:2],2'b00}.
REQ-021 Redirect in FETCH without ack -> DRAIN; the pending request completes at its original address and its data is dropped; DRAIN+ack -> FETCH at the new PC.
REQ-022 Redirect in FETCH with ack in the same cycle SHALL drop the data and go to FETCH at the new PC next cycle.
REQ-023 Redirect in IDLE SHALL go to FETCH at the new PC next cycle; a second redirect during DRAIN SHALL only update PC.
REQ-024 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-025 imem_ack while imem_req=0 SHALL be ignored.
REQ-026 Minimum latency: an ack in cycle N gives if_valid=1 with that instruction in cycle N+1.

Reset
REQ-027 While rst=1 at a rising edge: PC<=RESET_PC, FIFO empty, state IDLE, if_valid=0, imem_req=0, if_instr=0, if_pc=0.
REQ-028 rst SHALL override redirect and ack; a request outstanding at reset is abandoned, and any late ack is ignored per REQ-025.
REQ-029 On the first edge with rst=0 the FSM SHALL enter FETCH; imem_req=1 with imem_addr=32'h28 in that following cycle.

Verification
REQ-030 Zero-wait memory (ack tied high), if_ready=1 -> if_pc sequence 0x28, 0x2C, 0x30, one per cycle, if_instr equal to memory words 10, 11, 12.
REQ-031 if_ready=0, ack high -> exactly two pushes (0x28, 0x2C), then imem_req=0; after if_ready=1 for 1 cycle, a request for 0x30 is issued.
REQ-032 Ack delayed 3 cycles, redirect to 0x28 asserted in the second wait cycle -> imem_addr held at original address until ack; data dropped; next request addr 0x28; no if_valid until its ack.
REQ-033 redirect_addr=0x43 while the FIFO holds 2 entries -> if_valid=0 next cycle; next imem_addr=0x40.
REQ-034 Redirect to 0xFFFF_FFFC, ack high -> if_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-035 rst asserted mid-FETCH with the FIFO full -> next cycle if_valid=0, imem_req=0; after release, first imem_addr=0x28.

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end: holds the fetch PC, issues word-aligned
//   requests to instruction memory, and buffers returned words together with
//   their PCs in a 2-entry FIFO that feeds the decode stage.
//
// Parameters
//   RESET_PC       first fetch address after reset (byte address)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   redirect       taken branch/jump; restart fetching at redirect_addr
//   redirect_addr  new fetch address, bits [1:0] ignored
//   imem_req       instruction memory request valid
//   imem_addr      word-aligned byte address of the request
//   imem_ack       memory returns imem_data for the current request
//   imem_data      instruction word, sampled on imem_req && imem_ack
//   if_valid       FIFO head holds a valid instruction
//   if_instr       instruction at the FIFO head
//   if_pc          byte address of if_instr
//   if_ready       downstream consumes the head on if_valid && if_ready
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0028
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] redirect_pc;

  // FIFO storage: entry 0 is always the head.
  logic [31:0] e0_pc;
  logic [31:0] e0_instr;
  logic [31:0] e1_pc;
  logic [31:0] e1_instr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic [1:0]  occ_after_pop;
  logic [1:0]  occ_after;

  assign redirect_pc = {redirect_addr[31:2], 2'b00};

  // Pop needs a valid head; push only happens for a live (non-draining,
  // non-redirected) request, so acks while idle are ignored.
  assign pop  = (count != 2'd0) && if_ready;
  assign push = (state == FETCH) && imem_ack && !redirect;

  always_comb begin
    occ_after_pop = count - {1'b0, pop};
    occ_after     = occ_after_pop + {1'b0, push};
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A redirect flushes the FIFO, so it always leaves room to fetch.
        if (redirect || (occ_after_pop < 2'd2)) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          // An outstanding request must complete before fetching the new
          // target; if it completes this cycle its data is simply dropped.
          state_nxt = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          state_nxt = (occ_after < 2'd2) ? FETCH : IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      IDLE: begin
        imem_req  = 1'b0;
        imem_addr = pc;
      end
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
      end
      DRAIN: begin
        // PC may already hold the redirect target; the abandoned request
        // must keep presenting its original address until acked.
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Fetch PC and abandoned-request address
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      drain_addr <= '0;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else if (push) begin
        pc <= pc + 32'd4;
      end
      if ((state == FETCH) && redirect && !imem_ack) begin
        drain_addr <= pc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      e0_pc    <= '0;
      e0_instr <= '0;
      e1_pc    <= '0;
      e1_instr <= '0;
    end else if (redirect) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Simultaneous push and pop: occupancy unchanged, order kept.
          if (count == 2'd1) begin
            e0_pc    <= pc;
            e0_instr <= imem_data;
          end else begin
            e0_pc    <= e1_pc;
            e0_instr <= e1_instr;
            e1_pc    <= pc;
            e1_instr <= imem_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            e0_pc    <= pc;
            e0_instr <= imem_data;
            count    <= 2'd1;
          end else if (count == 2'd1) begin
            e1_pc    <= pc;
            e1_instr <= imem_data;
            count    <= 2'd2;
          end
        end
        2'b01: begin
          e0_pc    <= e1_pc;
          e0_instr <= e1_instr;
          count    <= count - 2'd1;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  assign if_valid = (count != 2'd0);
  assign if_pc    = e0_pc;
  assign if_instr = e0_instr;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed self-checking bench for instr_fetch. Instruction memory returns
//   {16'hC0DE, word index} for any address, so word 10 reads 32'hC0DE_000A.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  int unsigned n_checks;
  int unsigned n_fail;

  instr_fetch #(
    .RESET_PC(32'h0000_0028)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_ready     (if_ready)
  );

  assign imem_data = {16'hC0DE, imem_addr[17:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_addr = '0;
    imem_ack      = 1'b0;
    if_ready      = 1'b0;

    // Reset state
    cyc(); cyc();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc",    if_pc,    32'd0);

    // First edge out of reset enters FETCH at RESET_PC
    rst = 1'b0;
    cyc();
    check("boot_req",  {31'd0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, 32'h0000_0028);

    // Zero-wait streaming, one instruction per cycle, minimum latency
    imem_ack = 1'b1;
    if_ready = 1'b1;
    cyc();
    check("s0_valid", {31'd0, if_valid}, 32'd1);
    check("s0_pc",    if_pc,    32'h0000_0028);
    check("s0_instr", if_instr, 32'hC0DE_000A);
    cyc();
    check("s1_pc",    if_pc,    32'h0000_002C);
    check("s1_instr", if_instr, 32'hC0DE_000B);
    cyc();
    check("s2_pc",    if_pc,    32'h0000_0030);
    check("s2_instr", if_instr, 32'hC0DE_000C);
    check("s2_addr",  imem_addr, 32'h0000_0034);

    // Backpressure: exactly two pushes, then idle with ack still high
    rst = 1'b1; imem_ack = 1'b0; if_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    imem_ack = 1'b1;
    cyc();
    check("bp_addr1", imem_addr, 32'h0000_002C);
    cyc();
    check("bp_req_idle", {31'd0, imem_req}, 32'd0);
    check("bp_head",     if_pc, 32'h0000_0028);
    cyc();
    check("bp_req_hold", {31'd0, imem_req}, 32'd0);
    if_ready = 1'b1;
    cyc();
    if_ready = 1'b0;
    check("bp_req_resume", {31'd0, imem_req}, 32'd1);
    check("bp_addr_resume", imem_addr, 32'h0000_0030);
    check("bp_head2",      if_pc, 32'h0000_002C);

    // Redirect with misaligned target while FIFO holds two entries
    cyc();
    check("full_idle", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_addr = 32'h0000_0043;
    cyc();
    redirect = 1'b0; imem_ack = 1'b0;
    check("rd_flush", {31'd0, if_valid}, 32'd0);
    check("rd_req",   {31'd0, imem_req}, 32'd1);
    check("rd_addr",  imem_addr, 32'h0000_0040);

    // Reset with a request outstanding; late ack must be ignored
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    check("pre_rst_pc",   if_pc, 32'h0000_0040);
    check("pre_rst_addr", imem_addr, 32'h0000_0044);
    rst = 1'b1;
    cyc();
    check("mr_valid", {31'd0, if_valid}, 32'd0);
    check("mr_req",   {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    rst = 1'b0;
    cyc();
    check("mr_valid2", {31'd0, if_valid}, 32'd0);
    check("mr_addr",   imem_addr, 32'h0000_0028);

    // Delayed ack with redirects while the request is pending
    imem_ack = 1'b0;
    cyc();
    check("dl_hold1", imem_addr, 32'h0000_0028);
    redirect = 1'b1; redirect_addr = 32'h0000_0100;
    cyc();
    check("dl_hold2", imem_addr, 32'h0000_0028);
    redirect_addr = 32'h0000_0028;
    cyc();
    redirect = 1'b0;
    check("dl_hold3",   imem_addr, 32'h0000_0028);
    check("dl_valid3",  {31'd0, if_valid}, 32'd0);
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;
    check("dl_drop",    {31'd0, if_valid}, 32'd0);
    check("dl_new_req", {31'd0, imem_req}, 32'd1);
    check("dl_new_addr", imem_addr, 32'h0000_0028);
    cyc();
    check("dl_noack_valid", {31'd0, if_valid}, 32'd0);
    imem_ack = 1'b1;
    cyc();
    check("dl_valid", {31'd0, if_valid}, 32'd1);
    check("dl_pc",    if_pc,    32'h0000_0028);
    check("dl_instr", if_instr, 32'hC0DE_000A);

    // Redirect coinciding with ack, then PC wrap
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; if_ready = 1'b1;
    cyc();
    redirect = 1'b0;
    check("wr_flush", {31'd0, if_valid}, 32'd0);
    check("wr_addr",  imem_addr, 32'hFFFF_FFFC);
    cyc();
    check("wr_pc0",    if_pc,    32'hFFFF_FFFC);
    check("wr_instr0", if_instr, 32'hC0DE_FFFF);
    cyc();
    check("wr_pc1",    if_pc,    32'h0000_0000);
    check("wr_instr1", if_instr, 32'hC0DE_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
